// File: rtl/mio_pkg.sv
// Shared constants, FSM encoding and request header type for the MIO crossbar.
package mio_pkg;

    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned SADDR_W  = 28;
    localparam int unsigned REGION_W = 4;
    localparam int unsigned N_REGION = 16;
    localparam int unsigned MAP_W    = N_REGION * REGION_W;
    localparam int unsigned CNT_W    = 16;

    localparam logic [REGION_W-1:0] SLV_UNMAPPED       = 4'hF;
    localparam logic [MAP_W-1:0]    DEFAULT_REGION_MAP = 64'hFEDC_BA98_7654_3210;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_e;

    typedef struct packed {
        logic               we;
        logic [SADDR_W-1:0] addr;
    } req_hdr_t;

    // Slave index stored in the map nibble for a given 256 MB region.
    function automatic logic [REGION_W-1:0] region_field(
        input logic [MAP_W-1:0]    map,
        input logic [REGION_W-1:0] region
    );
        return map[{region, 2'b00} +: REGION_W];
    endfunction

endpackage

// File: rtl/mio_xbar_if.sv
// CPU-side and slave-side bus of the MIO crossbar; master = environment, slave = crossbar.
interface mio_xbar_if
    import mio_pkg::*;
#(
    parameter int unsigned N_SLV = 8,
    parameter int unsigned DW    = 32
);
    localparam int unsigned BW = DW / 8;

    logic                cpu_req;
    logic                cpu_we;
    logic [ADDR_W-1:0]   cpu_addr;
    logic [DW-1:0]       cpu_wdata;
    logic [BW-1:0]       cpu_be;
    logic                cpu_ready;
    logic                cpu_done;
    logic [DW-1:0]       cpu_rdata;
    logic                cpu_err;

    logic [N_SLV-1:0]    s_req;
    logic                s_we;
    logic [SADDR_W-1:0]  s_addr;
    logic [DW-1:0]       s_wdata;
    logic [BW-1:0]       s_be;
    logic [N_SLV-1:0]    s_ack;
    logic [N_SLV*DW-1:0] s_rdata;

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be, s_ack, s_rdata,
        input  cpu_ready, cpu_done, cpu_rdata, cpu_err, s_req, s_we, s_addr, s_wdata, s_be
    );

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata, cpu_be, s_ack, s_rdata,
        output cpu_ready, cpu_done, cpu_rdata, cpu_err, s_req, s_we, s_addr, s_wdata, s_be
    );

endinterface

// File: rtl/mio_decode.sv
// Combinational region decoder: addr[31:28] -> {hit, slave index} via REGION_MAP.
module mio_decode
    import mio_pkg::*;
#(
    parameter int unsigned      N_SLV      = 8,
    parameter logic [MAP_W-1:0] REGION_MAP = DEFAULT_REGION_MAP
) (
    input  logic [REGION_W-1:0] region,
    output logic                hit_c,
    output logic [REGION_W-1:0] idx_c
);

    logic [REGION_W-1:0] field_c;

    always_comb begin
        field_c = region_field(REGION_MAP, region);
        hit_c   = (32'(field_c) < N_SLV);
        idx_c   = hit_c ? field_c : SLV_UNMAPPED;
    end

endmodule

// File: rtl/mio_xbar.sv
// Single-outstanding CPU-to-N-slave crossbar with region decode.
// Optional ACCESS watchdog enabled by defining MIO_XBAR_TIMEOUT_EN.
module mio_xbar
    import mio_pkg::*;
#(
    parameter int unsigned      N_SLV      = 8,
    parameter int unsigned      DW         = 32,
    parameter logic [MAP_W-1:0] REGION_MAP = DEFAULT_REGION_MAP,
    parameter int unsigned      TIMEOUT    = 255
) (
    input  logic     clk,
    input  logic     rst_n,
    mio_xbar_if.slave bus
);

    localparam int unsigned BW = DW / 8;

    if (N_SLV < 2 || N_SLV > 15) begin : g_bad_n_slv
        $error("mio_xbar: N_SLV must be in 2..15");
    end
    if (DW == 0 || (DW % 8) != 0) begin : g_bad_dw
        $error("mio_xbar: DW must be a non-zero multiple of 8");
    end
    if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("mio_xbar: TIMEOUT must be in 1..65535");
    end

    state_e              state;
    req_hdr_t            hdr_q;
    logic [DW-1:0]       wdata_q;
    logic [BW-1:0]       be_q;
    logic [N_SLV-1:0]    s_req_q;
    logic                done_q;
    logic                err_q;
    logic [DW-1:0]       rdata_q;

    logic                dec_hit_c;
    logic [REGION_W-1:0] dec_idx_c;
    logic [N_SLV-1:0]    dec_onehot_c;
    logic                ack_c;
    logic [DW-1:0]       sel_rdata_c;

`ifdef MIO_XBAR_TIMEOUT_EN
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    logic [CNT_W-1:0] cnt_q;
`endif

    mio_decode #(
        .N_SLV      (N_SLV),
        .REGION_MAP (REGION_MAP)
    ) u_decode (
        .region (bus.cpu_addr[ADDR_W-1 -: REGION_W]),
        .hit_c  (dec_hit_c),
        .idx_c  (dec_idx_c)
    );

    // Acks and read data are qualified by the held one-hot request, so other slaves are ignored.
    always_comb begin
        dec_onehot_c = '0;
        sel_rdata_c  = '0;
        for (int i = 0; i < N_SLV; i++) begin
            dec_onehot_c[i] = dec_hit_c && (dec_idx_c == REGION_W'(i));
            if (s_req_q[i]) begin
                sel_rdata_c = bus.s_rdata[i*DW +: DW];
            end
        end
        ack_c = |(bus.s_ack & s_req_q);
    end

    assign bus.cpu_ready = (state == ST_IDLE) && bus.cpu_req;
    assign bus.cpu_done  = done_q;
    assign bus.cpu_err   = err_q;
    assign bus.cpu_rdata = rdata_q;
    assign bus.s_req     = s_req_q;
    assign bus.s_we      = hdr_q.we;
    assign bus.s_addr    = hdr_q.addr;
    assign bus.s_wdata   = wdata_q;
    assign bus.s_be      = be_q;

    // RESP entered with done low (unmapped path) spends one extra cycle so both paths give accept-to-done = 2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            hdr_q   <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            s_req_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= '0;
`ifdef MIO_XBAR_TIMEOUT_EN
            cnt_q   <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.cpu_req) begin
                        hdr_q.we   <= bus.cpu_we;
                        hdr_q.addr <= bus.cpu_addr[SADDR_W-1:0];
                        wdata_q    <= bus.cpu_wdata;
                        be_q       <= bus.cpu_be;
                        s_req_q    <= dec_onehot_c;
`ifdef MIO_XBAR_TIMEOUT_EN
                        cnt_q      <= '0;
`endif
                        state      <= dec_hit_c ? ST_ACCESS : ST_RESP;
                    end
                end
                ST_ACCESS: begin
                    if (ack_c) begin
                        s_req_q <= '0;
                        done_q  <= 1'b1;
                        err_q   <= 1'b0;
                        rdata_q <= hdr_q.we ? '0 : sel_rdata_c;
                        state   <= ST_RESP;
                    end
`ifdef MIO_XBAR_TIMEOUT_EN
                    else if (cnt_q == CNT_LAST) begin
                        s_req_q <= '0;
                        done_q  <= 1'b1;
                        err_q   <= 1'b1;
                        rdata_q <= '0;
                        state   <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
`endif
                end
                ST_RESP: begin
                    if (!done_q) begin
                        done_q  <= 1'b1;
                        err_q   <= 1'b1;
                        rdata_q <= '0;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
